tx_frame_reader: RTL

Egress framing stage that sits directly downstream of a first-word-fall-through `sync_fifo_core` instance (`P_FWFT=1`, `P_DATA_WIDTH=8`).
- It pops length-prefixed frames from the FIFO head and strips the 2-byte big-endian length header.
- It presents the payload as a byte stream with valid/ready/last to the port transmitter, then enforces an inter-frame gap.
- Frames whose header length is zero or exceeds the maximum are drained from the FIFO and reported as errors; they are never forwarded.

---
 rtl/tx_frame_reader_pkg.sv | 19 +
 rtl/ifg_counter.sv | 49 ++++
 rtl/tx_frame_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_reader_pkg.sv
// tx_frame_reader_pkg
//   Shared types and constants for the egress frame reader.
//   - tx_rd_state_e : reader FSM states
//   - C_HDR_BYTES   : length-prefix size in bytes (big-endian)
//   - C_ETH_MAX_LEN : default largest accepted payload length
package tx_frame_reader_pkg;

  typedef enum logic [2:0] {
    S_HDR_HI  = 3'd0,
    S_HDR_LO  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DISCARD = 3'd3,
    S_GAP     = 3'd4
  } tx_rd_state_e;

  localparam int C_HDR_BYTES   = 2;
  localparam int C_ETH_MAX_LEN = 1518;

endpackage

// File: rtl/ifg_counter.sv
// ifg_counter
//   Loadable down-counter with a done flag, used to time idle gaps
//   between egress frames.
//   Ports:
//     clk_i      : clock
//     rstn_i     : synchronous active-low reset (count cleared)
//     load_i     : load load_val_i into the counter (wins over en_i)
//     load_val_i : value to load
//     en_i       : decrement while the count is nonzero
//     done_o     : count is zero
module ifg_counter
  import tx_frame_reader_pkg::*;
#(
  parameter int P_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               load_i,
  input  logic [P_WIDTH-1:0] load_val_i,
  input  logic               en_i,
  output logic               done_o
);

  localparam logic [P_WIDTH-1:0] C_ONE = P_WIDTH'(1);

  logic [P_WIDTH-1:0] cnt_q;
  logic [P_WIDTH-1:0] cnt_d;

  // Saturates at zero so an enable held past the end never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_reader.sv
// tx_frame_reader
//   Egress framing stage fed by a first-word-fall-through byte FIFO.
//   Pops a 2-byte big-endian length header, forwards the payload as a
//   valid/ready/last byte stream, then idles for P_IFG cycles. Headers
//   with length 0 or above P_MAX_LEN are drained and flagged, never sent.
//   Optional statistics counters: define TX_FRAME_READER_STATS_EN.
//   Ports:
//     clk_i, rstn_i      : clock, synchronous active-low reset
//     fifo_data_i        : FIFO head byte (valid when fifo_empty_i low)
//     fifo_empty_i       : FIFO empty flag
//     fifo_rd_o          : pop request
//     tx_data_o          : payload byte
//     tx_valid_o         : tx_data_o valid
//     tx_ready_i         : downstream accepts the byte
//     tx_last_o          : final byte of the frame
//     busy_o             : reader is not waiting for a new header
//     len_err_o          : one-cycle pulse after a bad frame is drained
//     frame_cnt_o        : forwarded frames       (stats build only)
//     byte_cnt_o         : forwarded payload bytes (stats build only)
//     drop_cnt_o         : dropped bad frames     (stats build only)
module tx_frame_reader
  import tx_frame_reader_pkg::*;
#(
  parameter int P_LEN_WIDTH = 16,
  parameter int P_MAX_LEN   = C_ETH_MAX_LEN,
  parameter int P_IFG       = 12
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_last_o,
  output logic       busy_o,
  output logic       len_err_o
`ifdef TX_FRAME_READER_STATS_EN
  ,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] byte_cnt_o,
  output logic [31:0] drop_cnt_o
`endif
);

  localparam int                     C_HDR_WIDTH = C_HDR_BYTES * 8;
  localparam logic [P_LEN_WIDTH-1:0] C_MAX_LEN   = P_LEN_WIDTH'(P_MAX_LEN);
  localparam logic [P_LEN_WIDTH-1:0] C_ONE       = P_LEN_WIDTH'(1);
  localparam int                     C_GAP_WIDTH = (P_IFG > 1) ? $clog2(P_IFG) : 1;
  localparam logic [C_GAP_WIDTH-1:0] C_GAP_LOAD  = C_GAP_WIDTH'((P_IFG > 0) ? P_IFG - 1 : 0);

  tx_rd_state_e           state_q, state_d;
  logic [P_LEN_WIDTH-1:0] len_q, len_d;
  logic [P_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                   len_err_q, len_err_d;
  logic [P_LEN_WIDTH-1:0] hdr_len;
  logic                   gap_load;
  logic                   gap_en;
  logic                   gap_done;
  logic                   handshake;

  // The gap timer is loaded with P_IFG-1 on entry to S_GAP and the FSM
  // leaves when it reads zero, giving exactly P_IFG idle cycles.
  ifg_counter #(
    .P_WIDTH (C_GAP_WIDTH)
  ) u_ifg_counter (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (gap_load),
    .load_val_i (C_GAP_LOAD),
    .en_i       (gap_en),
    .done_o     (gap_done)
  );

  assign handshake = tx_valid_o && tx_ready_i;

  // Next-state and output logic. Every pop is gated by !fifo_empty_i, so
  // an underrun simply stalls the current state with remaining held.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    len_err_d   = 1'b0;
    fifo_rd_o   = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    tx_last_o   = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;

    // Full header length once the low byte sits at the FIFO head.
    hdr_len      = len_q;
    hdr_len[7:0] = fifo_data_i;

    case (state_q)
      S_HDR_HI: begin
        if (!fifo_empty_i) begin
          fifo_rd_o                    = 1'b1;
          len_d                        = '0;
          len_d[C_HDR_WIDTH-1 -: 8]    = fifo_data_i;
          state_d                      = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (!fifo_empty_i) begin
          fifo_rd_o = 1'b1;
          len_d     = hdr_len;
          if (hdr_len == '0) begin
            len_err_d = 1'b1;
            state_d   = S_HDR_HI;
          end else begin
            remaining_d = hdr_len;
            state_d     = (hdr_len > C_MAX_LEN) ? S_DISCARD : S_PAYLOAD;
          end
        end
      end

      // The FWFT head only changes on a pop, so data stays stable while
      // the downstream holds off.
      S_PAYLOAD: begin
        tx_valid_o = !fifo_empty_i;
        tx_data_o  = fifo_data_i;
        tx_last_o  = tx_valid_o && (remaining_q == C_ONE);
        fifo_rd_o  = handshake;
        if (handshake) begin
          remaining_d = remaining_q - C_ONE;
          if (remaining_q == C_ONE) begin
            if (P_IFG == 0) begin
              state_d = S_HDR_HI;
            end else begin
              gap_load = 1'b1;
              state_d  = S_GAP;
            end
          end
        end
      end

      // Oversized frames are drained byte by byte; the error pulse is
      // registered so it lands on the cycle after the final pop.
      S_DISCARD: begin
        if (!fifo_empty_i) begin
          fifo_rd_o   = 1'b1;
          remaining_d = remaining_q - C_ONE;
          if (remaining_q == C_ONE) begin
            len_err_d = 1'b1;
            state_d   = S_HDR_HI;
          end
        end
      end

      S_GAP: begin
        gap_en = 1'b1;
        if (gap_done) begin
          state_d = S_HDR_HI;
        end
      end

      default: begin
        state_d = S_HDR_HI;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_HDR_HI;
      len_q       <= '0;
      remaining_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      len_err_q   <= len_err_d;
    end
  end

  assign busy_o    = (state_q != S_HDR_HI);
  assign len_err_o = len_err_q;

`ifdef TX_FRAME_READER_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] byte_cnt_q,  byte_cnt_d;
  logic [31:0] drop_cnt_q,  drop_cnt_d;

  // Counters wrap naturally at 2^32. Drops are counted at the same edge
  // that raises len_err_o so both become visible together.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (handshake) begin
      byte_cnt_d = byte_cnt_q + 32'd1;
    end
    if (handshake && tx_last_o) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
    if (len_err_d) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign byte_cnt_o  = byte_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  // Without statistics the reader carries no counter state at all.
`endif

endmodule
